// File: rtl/apb_master_if.sv
// Bundle of the command/response handshake and APB bus signals for apb_master.
// The master modport is the requester view and the slave modport is the
// environment view (command source, response sink and APB completer).
interface apb_master_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   localparam int CW = 1 + DW + AW;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [CW-1:0] cmd_data;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          rsp_timeout;

   logic [AW-1:0] pADDR;
   logic [DW-1:0] pWDATA;
   logic          pWRITE;
   logic          pSEL;
   logic          pENABLE;
   logic [DW-1:0] pRDATA;
   logic          pREADY;
   logic          pSLVERR;

   modport master (
      input  cmd_valid, cmd_data, rsp_ready, pRDATA, pREADY, pSLVERR,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
             pADDR, pWDATA, pWRITE, pSEL, pENABLE
   );

   modport slave (
      output cmd_valid, cmd_data, rsp_ready, pRDATA, pREADY, pSLVERR,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
             pADDR, pWDATA, pWRITE, pSEL, pENABLE
   );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester. Takes one packed command
// {write, wdata, addr}, runs the SETUP/ACCESS phases, and holds the response
// until the consumer takes it. An ACCESS phase that waits too long is aborted
// with an error/timeout response (TIMEOUT = 0 waits forever).
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | pSEL=1, pENABLE=0, one cycle
//   ACCESS | pSEL=1, pENABLE=1, waiting for pREADY or timeout
//   RESP   | rsp_valid=1, held until rsp_ready
module apb_master #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input logic          pCLK,
   input logic          pRESETn,
   apb_master_if.master bus
);
   localparam int CW  = 1 + DW + AW;
   localparam int RW  = DW;
   // Counter must hold the value TIMEOUT itself; keep one bit when disabled.
   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WCW-1:0] TO_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [AW-1:0]  r_addr;
   logic [DW-1:0]  r_wdata;
   logic           r_write;
   logic [WCW-1:0] r_wait_cnt;
   logic [RW-1:0]  r_rsp_data;
   logic           r_rsp_err;
   logic           r_rsp_timeout;
   logic           w_accept;
   logic           w_done;
   logic           w_timeout_hit;

   assign w_accept      = (r_state == IDLE) && bus.cmd_valid;
   assign w_done        = (r_state == ACCESS) && bus.pREADY;
   // The ACCESS cycle that would bring the wait count up to TIMEOUT ends the transfer.
   assign w_timeout_hit = (TIMEOUT > 0) && (r_state == ACCESS) && !bus.pREADY &&
                          (r_wait_cnt == TO_LAST);

   // State register.
   always_ff @(posedge pCLK or negedge pRESETn) begin
      if (!pRESETn) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.cmd_valid) w_next = SETUP;
         SETUP:   w_next = ACCESS;
         ACCESS:  if (w_done || w_timeout_hit) w_next = RESP;
         RESP:    if (bus.rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Request fields are captured only on acceptance, so they stay stable through ACCESS.
   always_ff @(posedge pCLK or negedge pRESETn) begin
      if (!pRESETn) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= bus.cmd_data[AW-1:0];
         r_wdata <= bus.cmd_data[AW+DW-1:AW];
         r_write <= bus.cmd_data[CW-1];
      end
   end

   // Wait counter: cleared in SETUP, counts not-ready ACCESS cycles, saturates.
   always_ff @(posedge pCLK or negedge pRESETn) begin
      if (!pRESETn) begin
         r_wait_cnt <= '0;
      end else if (r_state == SETUP) begin
         r_wait_cnt <= '0;
      end else if ((r_state == ACCESS) && !bus.pREADY && (r_wait_cnt != '1)) begin
         r_wait_cnt <= r_wait_cnt + WCW'(1);
      end
   end

   // Response capture; pSLVERR/pRDATA are only looked at on the completing cycle.
   always_ff @(posedge pCLK or negedge pRESETn) begin
      if (!pRESETn) begin
         r_rsp_data    <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else if (w_done) begin
         r_rsp_data    <= r_write ? '0 : bus.pRDATA;
         r_rsp_err     <= bus.pSLVERR;
         r_rsp_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
         r_rsp_data    <= '0;
         r_rsp_err     <= 1'b1;
         r_rsp_timeout <= 1'b1;
      end
   end

   assign bus.cmd_ready   = (r_state == IDLE);
   assign bus.pSEL        = (r_state == SETUP) || (r_state == ACCESS);
   assign bus.pENABLE     = (r_state == ACCESS);
   assign bus.rsp_valid   = (r_state == RESP);
   assign bus.pADDR       = r_addr;
   assign bus.pWDATA      = r_wdata;
   assign bus.pWRITE      = r_write;
   assign bus.rsp_data    = r_rsp_data;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: directed cases plus randomized traffic. The
// expected response of each accepted command is pushed into a queue; a
// monitor pops and compares whenever the DUT presents a response.
module tb_apb_master;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 16;

   typedef struct {
      logic          write;
      logic [DW-1:0] wdata;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          err;
      logic          tmo;
      int            acc;
      int            lat;
      int            acc_cyc;
   } exp_t;

   typedef struct {
      int            wt;
      logic [DW-1:0] rdata;
      logic          slverr;
   } plan_t;

   logic  pCLK;
   logic  pRESETn;
   exp_t  exp_q[$];
   plan_t plan_q[$];
   int    tests   = 0;
   int    fails   = 0;
   int    cyc     = 0;
   int    last_hs = -100;
   int    rr_mode = 0;

   apb_master_if #(.DW(DW), .AW(AW)) bus ();

   apb_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
      .pCLK    (pCLK),
      .pRESETn (pRESETn),
      .bus     (bus)
   );

   initial begin
      pCLK = 1'b0;
      forever #5 pCLK = ~pCLK;
   end

   always @(posedge pCLK) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: outcome of one transaction from the slave's behaviour.
   function automatic exp_t model(input logic write, input logic [DW-1:0] wdata,
                                  input logic [AW-1:0] addr, input plan_t p, input int acc_cyc);
      exp_t e;
      e.write   = write;
      e.wdata   = wdata;
      e.addr    = addr;
      e.acc_cyc = acc_cyc;
      if (p.wt >= TO) begin
         e.data = '0;
         e.err  = 1'b1;
         e.tmo  = 1'b1;
         e.acc  = TO;
      end else begin
         e.data = write ? '0 : p.rdata;
         e.err  = p.slverr;
         e.tmo  = 1'b0;
         e.acc  = p.wt + 1;
      end
      e.lat = e.acc + 2;
      return e;
   endfunction

   // Offer a command from posedge+1 until accepted; register expectations on acceptance.
   task automatic do_txn(input logic write, input logic [DW-1:0] wdata, input logic [AW-1:0] addr,
                         input int wt, input logic [DW-1:0] rdata, input logic slverr,
                         input bit chk_b2b);
      plan_t p;
      int    n;
      p.wt           = wt;
      p.rdata        = rdata;
      p.slverr       = slverr;
      bus.cmd_valid  = 1'b1;
      bus.cmd_data   = {write, wdata, addr};
      n = 0;
      @(negedge pCLK);
      while (!bus.cmd_ready && n < 200) begin
         @(negedge pCLK);
         n++;
      end
      if (!bus.cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_wait: cmd_ready stayed 0 for %0d cycles, required 1", n);
      end else begin
         plan_q.push_back(p);
         exp_q.push_back(model(write, wdata, addr, p, cyc));
         if (chk_b2b) check("b2b_accept_cycle", 64'(cyc), 64'(last_hs + 1));
      end
      @(posedge pCLK);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = {1'b0, $urandom, $urandom};
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 500) begin
         @(posedge pCLK);
         n++;
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d responses outstanding after %0d cycles, required 0", exp_q.size(), n);
         exp_q.delete();
      end
      @(posedge pCLK);
      #1;
   endtask

   // APB completer following the per-transaction plan; garbage on ignored cycles.
   initial begin
      plan_t s_cur;
      int    s_acc;
      bus.pREADY  = 1'b0;
      bus.pRDATA  = '0;
      bus.pSLVERR = 1'b0;
      s_acc       = 0;
      s_cur.wt     = 0;
      s_cur.rdata  = '0;
      s_cur.slverr = 1'b0;
      forever begin
         @(posedge pCLK);
         #1;
         if (bus.pSEL && !bus.pENABLE) begin
            if (plan_q.size() > 0) s_cur = plan_q.pop_front();
            s_acc       = 0;
            bus.pREADY  = 1'($urandom);
            bus.pRDATA  = $urandom;
            bus.pSLVERR = 1'($urandom);
         end else if (bus.pSEL && bus.pENABLE) begin
            if (s_acc == s_cur.wt) begin
               bus.pREADY  = 1'b1;
               bus.pRDATA  = s_cur.rdata;
               bus.pSLVERR = s_cur.slverr;
            end else begin
               bus.pREADY  = 1'b0;
               bus.pRDATA  = $urandom;
               bus.pSLVERR = 1'($urandom);
            end
            s_acc++;
         end else begin
            bus.pREADY  = 1'($urandom);
            bus.pRDATA  = $urandom;
            bus.pSLVERR = 1'($urandom);
         end
      end
   end

   // Response consumer: always ready, random, or 5 cycles of backpressure.
   initial begin
      int hold;
      bus.rsp_ready = 1'b1;
      hold = 0;
      forever begin
         @(posedge pCLK);
         #1;
         if (bus.rsp_valid) hold++;
         else               hold = 0;
         case (rr_mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
            default: bus.rsp_ready = (hold > 5);
         endcase
      end
   end

   // Monitor: bus protocol, request stability, response scoreboard.
   initial begin
      exp_t          e;
      int            acc_seen;
      bit            rv_act;
      logic [DW-1:0] s_data;
      logic          s_err;
      logic          s_to;
      acc_seen = 0;
      rv_act   = 1'b0;
      forever begin
         @(negedge pCLK);
         if (!pRESETn) begin
            acc_seen = 0;
            rv_act   = 1'b0;
            continue;
         end
         if (bus.pSEL || bus.pENABLE) begin
            check("penable_needs_psel", 64'(bus.pSEL), 64'(1));
            check("psel_during_resp", 64'(bus.rsp_valid), 64'(0));
            check("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL psel_no_cmd: pSEL=1 with no accepted command outstanding");
            end else begin
               e = exp_q[0];
               check("pADDR", 64'(bus.pADDR), 64'(e.addr));
               check("pWDATA", 64'(bus.pWDATA), 64'(e.wdata));
               check("pWRITE", 64'(bus.pWRITE), 64'(e.write));
            end
            if (bus.pENABLE) acc_seen++;
         end
         if (!bus.rsp_valid && rv_act) begin
            tests++;
            fails++;
            $display("FAIL rsp_dropped: rsp_valid went 0 without handshake, required 1");
            rv_act = 1'b0;
         end
         if (bus.rsp_valid) begin
            check("cmd_ready_resp", 64'(bus.cmd_ready), 64'(0));
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rsp_unexpected: rsp_valid=1 data=0x%0h with no command outstanding", bus.rsp_data);
            end else begin
               e = exp_q[0];
               if (!rv_act) begin
                  check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                  check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                  check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.tmo));
                  check("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                  check("access_cycles", 64'(acc_seen), 64'(e.acc));
                  s_data = bus.rsp_data;
                  s_err  = bus.rsp_err;
                  s_to   = bus.rsp_timeout;
                  rv_act = 1'b1;
               end else begin
                  check("rsp_data_stable", 64'(bus.rsp_data), 64'(s_data));
                  check("rsp_err_stable", 64'(bus.rsp_err), 64'(s_err));
                  check("rsp_timeout_stable", 64'(bus.rsp_timeout), 64'(s_to));
               end
               if (bus.rsp_ready) begin
                  e        = exp_q.pop_front();
                  rv_act   = 1'b0;
                  acc_seen = 0;
                  last_hs  = cyc;
               end
            end
         end
      end
   end

   // Main stimulus.
   initial begin
      int n_rv;
      pRESETn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      #1;
      check("rst_pSEL", 64'(bus.pSEL), 64'(0));
      check("rst_pENABLE", 64'(bus.pENABLE), 64'(0));
      check("rst_pWRITE", 64'(bus.pWRITE), 64'(0));
      check("rst_pADDR", 64'(bus.pADDR), 64'(0));
      check("rst_pWDATA", 64'(bus.pWDATA), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
      check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
      check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'(0));
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      #21;
      pRESETn = 1'b1;
      @(posedge pCLK);
      #1;

      // Directed: write, read, wait states with error, timeout boundary.
      do_txn(1'b1, 32'h0000_A5A5, 32'h0000_0004, 0, $urandom, 1'b0, 1'b0);
      wait_idle();
      do_txn(1'b0, $urandom, 32'h0000_0000, 0, 32'h0000_1234, 1'b0, 1'b0);
      wait_idle();
      do_txn(1'b0, $urandom, 32'h0000_0010, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);
      wait_idle();
      do_txn(1'b0, $urandom, 32'h0000_0020, 15, 32'hCAFE_F00D, 1'b0, 1'b0);
      wait_idle();
      do_txn(1'b0, $urandom, 32'h0000_0030, TO, 32'h1111_2222, 1'b0, 1'b0);
      wait_idle();
      do_txn(1'b1, $urandom, 32'h0000_0040, 100, $urandom, 1'b0, 1'b0);
      wait_idle();

      // Backpressure with the next command already pending.
      rr_mode = 2;
      do_txn(1'b0, $urandom, 32'h0000_0050, 1, 32'h5555_AAAA, 1'b0, 1'b0);
      do_txn(1'b1, $urandom, 32'h0000_0054, 0, $urandom, 1'b0, 1'b1);
      wait_idle();

      // Peak throughput burst.
      rr_mode = 0;
      do_txn(1'b0, $urandom, $urandom, 0, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         do_txn(1'($urandom), $urandom, $urandom, 0, $urandom, 1'($urandom), 1'b1);
      wait_idle();

      // Randomized traffic.
      rr_mode = 1;
      for (int i = 0; i < 200; i++) begin
         int wt;
         if ($urandom_range(0, 3) == 0) wt = $urandom_range(0, 20);
         else                           wt = $urandom_range(0, 3);
         do_txn(1'($urandom), $urandom, $urandom, wt, $urandom, 1'($urandom), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge pCLK);
            #1;
         end
      end
      wait_idle();

      // Reset in the middle of ACCESS.
      rr_mode = 0;
      do_txn(1'b0, $urandom, 32'h0000_0060, 50, $urandom, 1'b0, 1'b0);
      repeat (3) @(posedge pCLK);
      #2;
      check("pre_rst_in_access", 64'(bus.pSEL & bus.pENABLE), 64'(1));
      pRESETn = 1'b0;
      #1;
      check("arst_pSEL", 64'(bus.pSEL), 64'(0));
      check("arst_pENABLE", 64'(bus.pENABLE), 64'(0));
      check("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("arst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("arst_pADDR", 64'(bus.pADDR), 64'(0));
      check("arst_rsp_data", 64'(bus.rsp_data), 64'(0));
      exp_q.delete();
      plan_q.delete();
      #4;
      pRESETn = 1'b1;
      @(negedge pCLK);
      check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      n_rv = 0;
      repeat (30) begin
         @(negedge pCLK);
         if (bus.rsp_valid) n_rv++;
      end
      check("post_rst_no_rsp", 64'(n_rv), 64'(0));
      @(posedge pCLK);
      #1;
      do_txn(1'b0, $urandom, 32'h0000_0070, 2, 32'h7777_0001, 1'b0, 1'b0);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
